// File: rtl/vga_cap_pkg.sv
// ---------------------------------------------------------------------------
// vga_cap_pkg
//   Shared definitions for the VGA frame capture block.
//   - cap_state_e : capture FSM state encoding
//   - default 640x480 timing constants, identical to the display driver's
//     800/521/96/2/144/784/31/511 set, so the two sides stay in lock-step
//   - luma()      : 3-3-2 RGB to 5-bit unsigned brightness sum
// ---------------------------------------------------------------------------
package vga_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  // Display driver timing (pixel clock cycles / lines)
  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 521;
  localparam int H_SYNC_W    = 96;
  localparam int V_SYNC_W    = 2;
  localparam int H_ACT_START = 144;
  localparam int H_ACT_END   = 784;
  localparam int V_ACT_START = 31;
  localparam int V_ACT_END   = 511;

  localparam int LUMA_THRESH = 9;

  // Position counters are 10 bits wide and saturate instead of wrapping,
  // so a missing sync never aliases back into the active window.
  localparam int              CNT_W   = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = 10'd1023;

  // Value of an idle (deasserted) active-low sync line.
  localparam logic SYNC_IDLE = 1'b1;

  function automatic logic [4:0] luma(input logic [2:0] r,
                                      input logic [2:0] g,
                                      input logic [1:0] b);
    return 5'(r) + 5'(g) + 5'(b);
  endfunction

endpackage

// File: rtl/vga_sync_edge_det.sv
// ---------------------------------------------------------------------------
// vga_sync_edge_det
//   Input register plus falling-edge detector for one active-low sync line.
//   Both flops reset to the idle level, so leaving reset never looks like
//   a sync edge.
//
// Ports
//   dclk    in   pixel clock
//   clr     in   asynchronous active-high reset
//   sync_i  in   raw sync pin (active low)
//   fall_o  out  high for one cycle when the registered sync goes 1 -> 0
// ---------------------------------------------------------------------------
module vga_sync_edge_det
  import vga_cap_pkg::*;
(
  input  logic dclk,
  input  logic clr,
  input  logic sync_i,
  output logic fall_o
);

  logic sync_q;   // pin sampled once
  logic prev_q;   // previous value of sync_q

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      sync_q <= SYNC_IDLE;
      prev_q <= SYNC_IDLE;
    end else begin
      sync_q <= sync_i;
      prev_q <= sync_q;
    end
  end

  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/vga_frame_capture.sv
// ---------------------------------------------------------------------------
// vga_frame_capture
//   Samples a VGA stream (active-low hsync/vsync, 3-3-2 RGB) on the pixel
//   clock, recovers the pixel position from the sync falling edges and, for
//   one requested frame, writes a thresholded 1-bit value per active pixel
//   into the bitmap RAM in raster order.
//
// Build option
//   VGA_CAP_LINE_CHECK_EN : when defined, every hsync edge during a capture
//                           must close a line of exactly HTOTAL cycles, or
//                           the capture aborts with sync_err.
//
// Ports
//   dclk         in   pixel clock
//   clr          in   asynchronous active-high reset
//   hsync        in   horizontal sync, active low
//   vsync        in   vertical sync, active low
//   red/green    in   3-bit colour components
//   blue         in   2-bit colour component
//   capture_req  in   single-cycle request to capture the next frame
//   wr_en        out  bitmap RAM write strobe
//   wr_addr      out  write address, y*WIDTH+x
//   wr_data      out  1 when red+green+blue >= THRESH
//   busy         out  capture in progress (FSM not idle)
//   frame_done   out  one-cycle pulse after the last write of a frame
//   sync_err     out  sticky: early vsync (or bad line length); cleared by
//                     the next accepted capture_req
// ---------------------------------------------------------------------------
module vga_frame_capture
  import vga_cap_pkg::*;
#(
  parameter int WIDTH  = H_ACT_END - H_ACT_START,
  parameter int HEIGHT = V_ACT_END - V_ACT_START,
  parameter int HBP    = H_ACT_START,
  parameter int VBP    = V_ACT_START,
  parameter int HTOTAL = H_TOTAL,
  parameter int THRESH = LUMA_THRESH,
  parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic              dclk,
  input  logic              clr,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [2:0]        red,
  input  logic [2:0]        green,
  input  logic [1:0]        blue,
  input  logic              capture_req,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              sync_err
);

  localparam logic [CNT_W-1:0]  H_START   = CNT_W'(HBP);
  localparam logic [CNT_W-1:0]  H_STOP    = CNT_W'(HBP + WIDTH);
  localparam logic [CNT_W-1:0]  V_START   = CNT_W'(VBP);
  localparam logic [CNT_W-1:0]  V_STOP    = CNT_W'(VBP + HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [4:0]        THRESH_L  = 5'(THRESH);
`ifdef VGA_CAP_LINE_CHECK_EN
  // hc value seen at the closing hsync edge of a correctly sized line.
  localparam logic [CNT_W-1:0]  HC_LINE_END = CNT_W'(HTOTAL - 1);
`endif

  // -------------------------------------------------------------------------
  // Input stage: sync edge detectors (bit 0 = hsync, bit 1 = vsync) and the
  // colour register, all one cycle behind the pins.
  // -------------------------------------------------------------------------
  logic [1:0] sync_pins;
  logic [1:0] sync_fall;
  logic       hs_fall;
  logic       vs_fall;

  assign sync_pins = {vsync, hsync};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      vga_sync_edge_det u_edge (
        .dclk   (dclk),
        .clr    (clr),
        .sync_i (sync_pins[gi]),
        .fall_o (sync_fall[gi])
      );
    end
  endgenerate

  assign hs_fall = sync_fall[0];
  assign vs_fall = sync_fall[1];

  logic [2:0] red_q;
  logic [2:0] green_q;
  logic [1:0] blue_q;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red;
      green_q <= green;
      blue_q  <= blue;
    end
  end

  // -------------------------------------------------------------------------
  // Position counters.
  // The colour in red_q/green_q/blue_q is the pixel that arrived together
  // with the edge being detected this cycle, so that pixel's coordinates
  // are the *next* counter values (hc_d/vc_d), not hc_q/vc_q. Using the
  // next values keeps the pin-to-write latency at two cycles.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;

    if (hs_fall) begin
      hc_d = '0;
    end else if (hc_q != CNT_MAX) begin
      hc_d = hc_q + 10'd1;
    end

    // vsync edge wins over a coincident hsync edge.
    if (vs_fall) begin
      vc_d = '0;
    end else if (hs_fall && (vc_q != CNT_MAX)) begin
      vc_d = vc_q + 10'd1;
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  logic pix_active;
  logic pix_bright;

  assign pix_active = (hc_d >= H_START) && (hc_d < H_STOP) &&
                      (vc_d >= V_START) && (vc_d < V_STOP);
  assign pix_bright = (luma(red_q, green_q, blue_q) >= THRESH_L);

  // -------------------------------------------------------------------------
  // Capture FSM and output register.
  // -------------------------------------------------------------------------
  cap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sync_err_q, sync_err_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_data_q, wr_data_d;
  logic              busy_q;
  logic              frame_done_q;
  logic              line_err;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sync_err_d = sync_err_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = '0;
    wr_data_d  = 1'b0;
    line_err   = 1'b0;

`ifdef VGA_CAP_LINE_CHECK_EN
    // hc_q still holds the length of the line that this edge closes.
    line_err = hs_fall && (hc_q != HC_LINE_END);
`endif

    unique case (state_q)
      IDLE: begin
        // A sync edge in this same cycle is deliberately not acted on;
        // the capture waits for the following vsync edge in ARM.
        if (capture_req) begin
          state_d    = ARM;
          sync_err_d = 1'b0;
        end
      end

      ARM: begin
        if (vs_fall) begin
          state_d = CAPTURE;
          addr_d  = '0;
        end
      end

      CAPTURE: begin
        if (vs_fall || line_err) begin
          sync_err_d = 1'b1;
          state_d    = IDLE;
        end else if (pix_active) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = pix_bright;
          addr_d    = addr_q + ADDR_W'(1);
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      sync_err_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sync_err_q   <= sync_err_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      // busy and frame_done are registered from state_q so they sit in the
      // same output stage as the writes: frame_done follows the last write,
      // and busy is still high while frame_done (or a new sync_err) shows.
      busy_q       <= (state_q != IDLE);
      frame_done_q <= (state_q == DONE);
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule
